// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of a 4-digit multiplexed 7-segment display.
// Latency: grant and snapshot one clk after a request is seen; handover only at frame end.
// Optional: `define SEG_BLANK_LEADING_ZERO_EN to blank leading zero digits (digit 0 never blanked).
module seg_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int DIVW        = 26,
  parameter int SHIFT0      = 15,
  parameter int SHIFT1      = 19,
  parameter int SHIFT2      = 25,
  parameter int HOLD_FRAMES = 8,
  localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW         = $clog2(HOLD_FRAMES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [16*NREQ-1:0] data_i,
  input  logic [1:0]        speed_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [OW-1:0]     owner_o,
  output logic              busy_o,
  output logic              frame_end_o,
  output logic [3:0]        grounds_o,
  output logic [6:0]        display_o
);

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q;
  logic [DIVW-1:0] presc_q;
  logic [1:0]      dig_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [OW-1:0]   last_q;
  logic [15:0]     snap_q;
  logic [DIVW-1:0] term;
  logic            tick;
  logic            ovf;
  logic            idle_hit;
  logic [OW-1:0]   idle_idx;
  logic            ho_hit;
  logic [OW-1:0]   ho_idx;
  logic            own_req;
  logic [3:0]      nib;
  logic            blank;

  // Round-robin search starting just after base; skip_base excludes base itself.
  function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] base,
                                          input logic skip_base);
    int          best;
    int          d;
    logic        hit;
    logic [OW-1:0] sel;
    best = NREQ;
    hit  = 1'b0;
    sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && !(skip_base && (OW'(i) == base))) begin
        d = (i + 2 * NREQ - 1 - int'(base)) % NREQ;
        if (d < best) begin
          best = d;
          sel  = OW'(i);
          hit  = 1'b1;
        end
      end
    end
    return {hit, sel};
  endfunction

  function automatic logic [15:0] pick_data(input logic [OW-1:0] sel);
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == sel) v = data_i[16*i +: 16];
    end
    return v;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] sel);
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = (OW'(i) == sel);
    return v;
  endfunction

  function automatic logic [3:0] gnd(input logic [1:0] d);
    case (d)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Scan terminal count for the selected speed, tick/overflow detection and arbitration picks.
  always_comb begin
    case (speed_i)
      2'd1:    term = DIVW'((64'd1 << SHIFT1) - 64'd1);
      2'd2:    term = DIVW'((64'd1 << SHIFT2) - 64'd1);
      default: term = DIVW'((64'd1 << SHIFT0) - 64'd1);
    endcase
    tick                 = (presc_q == term);
    ovf                  = (presc_q > term);
    {idle_hit, idle_idx} = rr_pick(req_i, last_q, 1'b0);
    {ho_hit, ho_idx}     = rr_pick(req_i, owner_o, 1'b1);
    own_req              = |(req_i & grant_o);
    cnt_d                = (cnt_q >= CW'(HOLD_FRAMES)) ? cnt_q : cnt_q + CW'(1);
  end

  // Arbitration FSM, scan position, snapshot and registered display-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      dig_q       <= 2'd0;
      cnt_q       <= '0;
      last_q      <= OW'(NREQ - 1);
      snap_q      <= 16'h0000;
      grant_o     <= '0;
      owner_o     <= '0;
      busy_o      <= 1'b0;
      frame_end_o <= 1'b0;
      grounds_o   <= 4'b1111;
    end else begin
      presc_q     <= (tick || ovf) ? '0 : presc_q + DIVW'(1);
      frame_end_o <= 1'b0;
      case (state_q)
        IDLE: begin
          grounds_o <= 4'b1111;
          if (idle_hit) begin
            state_q   <= OWN;
            grant_o   <= onehot(idle_idx);
            owner_o   <= idle_idx;
            last_q    <= idle_idx;
            busy_o    <= 1'b1;
            snap_q    <= pick_data(idle_idx);
            presc_q   <= '0;
            dig_q     <= 2'd0;
            cnt_q     <= '0;
            grounds_o <= 4'b1110;
          end
        end
        OWN: begin
          if (tick) begin
            if (dig_q == 2'd3) begin
              frame_end_o <= 1'b1;
              dig_q       <= 2'd0;
              grounds_o   <= 4'b1110;
              if (!own_req && !ho_hit) begin
                state_q   <= IDLE;
                grant_o   <= '0;
                owner_o   <= '0;
                busy_o    <= 1'b0;
                cnt_q     <= '0;
                grounds_o <= 4'b1111;
              end else if (ho_hit && (!own_req || cnt_d >= CW'(HOLD_FRAMES))) begin
                grant_o <= onehot(ho_idx);
                owner_o <= ho_idx;
                last_q  <= ho_idx;
                snap_q  <= pick_data(ho_idx);
                cnt_q   <= '0;
              end else begin
                cnt_q  <= cnt_d;
                snap_q <= pick_data(owner_o);
              end
            end else begin
              dig_q     <= dig_q + 2'd1;
              grounds_o <= gnd(dig_q + 2'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Segment decode of the snapshot nibble for the digit being scanned.
  always_comb begin
    case (dig_q)
      2'd0:    nib = snap_q[3:0];
      2'd1:    nib = snap_q[7:4];
      2'd2:    nib = snap_q[11:8];
      default: nib = snap_q[15:12];
    endcase
    blank = 1'b0;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    case (dig_q)
      2'd1:    blank = (snap_q[15:4] == 12'h000);
      2'd2:    blank = (snap_q[15:8] == 8'h00);
      2'd3:    blank = (snap_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    display_o = (state_q == OWN && !blank) ? seg7(nib) : 7'b0000000;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the 4-digit multiplexed seven-segment display between NREQ requesters.
- Each requester presents a 16-bit hex value (4 nibbles). The block grants ownership round-robin with a minimum hold time in scan frames.
- Owns digit scanning: prescaler, selectable scan speed, ground rotation, and segment decode. Sits between the counter/status sources and the display pins.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DIVW, 26, prescaler counter width
- SHIFT0, 15, speed 0 scan-tick period = 2^SHIFT0 clk
- SHIFT1, 19, speed 1 scan-tick period = 2^SHIFT1 clk
- SHIFT2, 25, speed 2 scan-tick period = 2^SHIFT2 clk (speed 3 aliases speed 0)
- HOLD_FRAMES, 8, minimum completed frames an owner keeps the display when others are pending (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester, level-sensitive
- data  in  16*NREQ  requester i value at bits [16i+15:16i]; nibble 0 is digit 0
- speed  in  2  scan speed select
- grant  out  NREQ  one-hot owner, all-zero when idle
- owner  out  max(1,$clog2(NREQ))  index of current owner
- busy  out  1  display owned
- frame_end  out  1  one-clk pulse on the scan tick that completes digit 3
- grounds  out  4  active-low digit enables
- display  out  7  segments a (bit 6) .. g (bit 0), active-high

Behaviour:
- Reset values: grounds=4'b1111, display=7'b0000000, grant=0, owner=0, busy=0, frame_end=0. Internally: prescaler=0, digit index=0, frame count=0, last-owner pointer=NREQ-1, so the first grant goes to req[0].
- Prescaler: increments every clk.
  - Scan tick fires when the prescaler equals 2^SHIFTsel-1; the prescaler then returns to 0.
  - On a speed change with prescaler >= the new terminal, the prescaler clears to 0 the next clk with no tick.
- FSM has two states, IDLE and OWN.
- IDLE:
  - grounds=1111, display=0.
  - When any req is high, search round-robin starting at last-owner+1 (mod NREQ) for the first requester with req high.
  - Next clk: enter OWN, assert grant/owner, snapshot that requester's data, clear prescaler, digit index and frame count.
- OWN:
  - grounds is the active-low one-hot of the digit index: digit 0 gives 1110, digit 1 gives 1101, and so on.
  - display is the decode of the snapshot nibble for the current digit.
  - The digit index advances on each scan tick and wraps 3->0.
- Frame end (tick while digit index=3):
  - frame_end pulses for that clk.
  - Frame count increments, saturating at HOLD_FRAMES.
  - The snapshot reloads from the current owner's data. The display never mixes values within a frame.
- Handover is evaluated only at frame end:
  - (a) Owner req low and another req high: grant the next requester round-robin after the owner.
  - (b) Owner req low and no other req: return to IDLE, grant=0.
  - (c) Owner req high, frame count (after increment) >= HOLD_FRAMES, and another req high: rotate to the next requester after the owner.
  - (d) Otherwise keep the owner.
  - On handover: snapshot the new data, restart the frame count at 0, and keep the digit index at 0. The new owner is visible from the next clk.
- Round-robin skips requesters with req low. A lone requester keeps the display indefinitely. The last-owner pointer updates on every grant.
- Owner dropping req mid-frame: the frame completes with the snapshot value, then the handover rule applies.
- Segment decode, value -> abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- rst asserted mid-frame or mid-handover returns all state to reset values on that clk edge.
- All outputs are registered except display, which is a combinational decode of registered state.

Optional Feature:
- Macro: SEG_BLANK_LEADING_ZERO_EN.
- Defined: in OWN, any digit whose nibble and all higher nibbles of the snapshot are 0 shows display=0000000. Digit 0 is never blanked, so value 0x0000 shows a single "0" and 0x00A3 shows "A3".
- Undefined: all four digits always decode, so 0x00A3 shows "00A3".

Test Plan (SHIFT0=2, SHIFT1=3, SHIFT2=4, HOLD_FRAMES=2, NREQ=4):
- Reset check: rst high 2 clk then low with no req -> grounds=1111, display=0000000, grant=0000, busy=0.
- Single owner scan: req=0001, data0=16'h1234, speed=0 -> grant=0001 one clk after req. grounds cycles 1110,1101,1011,0111, each held 4 clk. display shows 4,3,2,1 (0110011, 1111001, 1101101, 0110000). frame_end pulses every 16 clk.
- Rotation with hold: req=0101 held -> owner 0 for exactly 2 frames, then owner 2 for 2 frames, then back to owner 0. grant never changes except at a frame_end clk.
- Owner drop mid-frame: owner 0 drops req at digit 1 with req[3] high -> frame completes with the old snapshot, then grant=1000. With no other req -> IDLE, grounds=1111.
- Speed change: speed 2->0 while prescaler=10 -> prescaler clears with no tick; subsequent ticks every 4 clk. Speed 3 behaves as speed 0.
- Snapshot coherency: data0 changes 0xAAAA->0x5555 at digit 2 -> remaining digits of that frame show A (1110111). The next frame shows 5 (1011011).
